pixel_array_ctrl: RTL
=====================

Name: pixel_array_ctrl

Overview:
- Sequencer and readout master for the 2x2 pixel array.
- Drives the array's control inputs through one frame: erase, expose, ramp-convert, then row-by-row read.
- Drives the 8-bit counter code onto the shared data buses during conversion.
- Captures the pixel codes the array drives back during read and streams them out over a valid/ready interface to the downstream frame consumer.
- Tristate resolution of pixData1/pixData2 is done at the top level; this block uses separate in, out and drive-enable signals.

Parameters:
- DATA_W, 8, pixel code width and counter width.
- ERASE_CYCLES, 5, cycles pixel_erase and mem_reset are held high.
- EXP_W, 16, width of the expose_time input.
- READ_SETTLE, 2, cycles mem_read is held before the buses are sampled.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous reset, active-high.
- start  in  1  one-cycle frame request; ignored unless idle.
- expose_time  in  EXP_W  exposure length in cycles; sampled on the accepted start.
- busy  out  1  high from the accepted start until the last word is accepted.
- bias_en  out  1  pixel bias enable (VBN1 source).
- ramp_en  out  1  ramp generator enable.
- mem_reset  out  1  pixel memory reset.
- pixel_erase  out  1  pixel erase.
- pixel_expose  out  1  pixel expose.
- mem_read  out  2  row select; bit1 = row 1, bit0 = row 2; one-hot or zero.
- cnt_drive_en  out  1  high = controller drives cnt_value onto both data buses.
- cnt_value  out  DATA_W  conversion counter code.
- pix_data1_in  in  DATA_W  column-1 bus value.
- pix_data2_in  in  DATA_W  column-2 bus value.
- out_data  out  DATA_W  pixel code.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts when out_valid & out_ready.
- out_last  out  1  marks the 4th word of the frame.

Behaviour:
- Reset: all outputs 0, state IDLE. Reset mid-frame aborts immediately and takes priority over every other event.
- All outputs are registered.

FSM states and transitions:
- IDLE: start=1 latches expose_time and goes to ERASE; busy rises the next cycle.
- ERASE:
  - bias_en=1, pixel_erase=1, mem_reset=1 for exactly ERASE_CYCLES cycles.
  - Then EXPOSE.
- EXPOSE:
  - bias_en=1, pixel_expose=1 for max(expose_time,1) cycles, so expose_time=0 gives 1 cycle.
  - Then CONVERT.
- CONVERT:
  - bias_en=1, ramp_en=1, cnt_drive_en=1.
  - cnt_value = 0 in the first cycle, +1 per cycle up to 2^DATA_W-1 inclusive; 256 cycles at DATA_W=8, no wrap.
  - Then READ with row=1.
  - cnt_drive_en falls the same edge that leaves CONVERT; mem_read rises one cycle later (1-cycle bus turnaround, bus never double-driven).
- READ:
  - mem_read one-hot for the current row (row 1 uses bit1) for READ_SETTLE cycles.
  - On the last settle cycle, register pix_data1_in and pix_data2_in into a 2-entry buffer.
  - mem_read=0 the next cycle; then EMIT.
- EMIT:
  - Present column-1 word, then column-2 word.
  - out_valid stays high and out_data/out_last stay stable while out_ready=0.
  - Each word advances only on out_valid & out_ready.
  - After row 1 go to READ row 2; after row 2 go to IDLE.
  - Word order: ps11, ps12, ps21, ps22. out_last=1 with the 4th word only.
  - busy falls the cycle after the 4th word is accepted; start is accepted in that same cycle (IDLE).
- start while busy: ignored, no queueing.
- Outside its state, each control output is 0. mem_read is never asserted together with cnt_drive_en.

Decomposition:
- Shared package pixel_ctrl_pkg holds:
  - typedef state_t {IDLE, ERASE, EXPOSE, CONVERT, READ, EMIT};
  - localparams NUM_ROWS=2, NUM_COLS=2;
  - the row-to-mem_read bit mapping.
- One sub-module, pixel_read_buffer: the 2-entry capture register plus valid/ready emit logic with the out_last flag.

Test Plan:
- Reset, then start with expose_time=10 and out_ready=1:
  - pixel_erase high exactly 5 cycles, pixel_expose exactly 10, ramp_en/cnt_drive_en exactly 256 with cnt_value 0..255.
  - Bus model returning 0x11,0x12 (row 1) and 0x21,0x22 (row 2) yields out_data 11,12,21,22, out_last on 22, then busy=0.
- expose_time=0 -> pixel_expose high exactly 1 cycle.
- out_ready low for 7 cycles on word 2 -> out_data=0x12 and out_valid held stable, no word lost or duplicated, mem_read stays 0 while stalled.
- start pulsed during EXPOSE and during EMIT -> ignored, exactly one frame of 4 words.
- reset asserted mid-CONVERT at cnt_value=100 -> next cycle all outputs 0 and IDLE; a fresh start runs a full correct frame.
- Every cycle: assertion that mem_read!=0 implies cnt_drive_en==0 and the previous cycle's cnt_drive_en==0; mem_read is never 2'b11.

Source files
------------

// File: rtl/pixel_ctrl_pkg.sv
// Shared types and constants for the 2x2 pixel array sequencer.
package pixel_ctrl_pkg;

  typedef enum logic [2:0] {IDLE, ERASE, EXPOSE, CONVERT, READ, EMIT} state_t;

  localparam int NUM_ROWS = 2;
  localparam int NUM_COLS = 2;

  // Row index 0 is array row 1 and is selected by mem_read bit 1.
  function automatic logic [NUM_ROWS-1:0] row_to_mem_read(input logic row);
    logic [NUM_ROWS-1:0] sel;
    case (row)
      1'b0:    sel = 2'b10;
      default: sel = 2'b01;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/pixel_read_buffer.sv
// Holds one captured row (one word per column) and emits it column by column
// over valid/ready, flagging the final word of the frame.
module pixel_read_buffer
  import pixel_ctrl_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              capture,
  input  logic              last_row,
  input  logic [DATA_W-1:0] col1_in,
  input  logic [DATA_W-1:0] col2_in,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_last,
  output logic              row_done
);

  logic [DATA_W-1:0] buf_q [NUM_COLS];
  logic [DATA_W-1:0] buf_d [NUM_COLS];
  logic              col_q, col_d;
  logic              valid_q, valid_d;
  logic              last_row_q, last_row_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic              accept;

  always_comb begin
    buf_d      = buf_q;
    col_d      = col_q;
    valid_d    = valid_q;
    last_row_d = last_row_q;
    accept     = valid_q & out_ready;
    if (capture) begin
      buf_d[0]   = col1_in;
      buf_d[1]   = col2_in;
      col_d      = 1'b0;
      valid_d    = 1'b1;
      last_row_d = last_row;
    end else if (accept) begin
      if (col_q == 1'(NUM_COLS - 1)) valid_d = 1'b0;
      else                           col_d   = col_q + 1'b1;
    end
    // Output word is re-registered so it is glitch-free and held during a stall.
    out_data_d = valid_d ? buf_d[col_d] : '0;
    out_last_d = valid_d & last_row_d & (col_d == 1'(NUM_COLS - 1));
  end

  assign row_done = accept & (col_q == 1'(NUM_COLS - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_COLS; i++) buf_q[i] <= '0;
      col_q      <= 1'b0;
      valid_q    <= 1'b0;
      last_row_q <= 1'b0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
    end else begin
      buf_q      <= buf_d;
      col_q      <= col_d;
      valid_q    <= valid_d;
      last_row_q <= last_row_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = valid_q;
  assign out_last  = out_last_q;

endmodule

// File: rtl/pixel_array_ctrl.sv
// Frame sequencer for the 2x2 pixel array: erase, expose, ramp-convert, then
// row-by-row readout streamed to a valid/ready consumer.
module pixel_array_ctrl
  import pixel_ctrl_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int ERASE_CYCLES = 5,
  parameter int EXP_W        = 16,
  parameter int READ_SETTLE  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [EXP_W-1:0]  expose_time,
  output logic              busy,
  output logic              bias_en,
  output logic              ramp_en,
  output logic              mem_reset,
  output logic              pixel_erase,
  output logic              pixel_expose,
  output logic [1:0]        mem_read,
  output logic              cnt_drive_en,
  output logic [DATA_W-1:0] cnt_value,
  input  logic [DATA_W-1:0] pix_data1_in,
  input  logic [DATA_W-1:0] pix_data2_in,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  localparam int CNT_W = ((EXP_W > DATA_W) ? EXP_W : DATA_W) + 1;
  localparam logic [CNT_W-1:0] ERASE_LAST  = CNT_W'(ERASE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CONV_LAST   = CNT_W'((1 << DATA_W) - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(READ_SETTLE);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [EXP_W-1:0]  exp_q, exp_d;
  logic              row_q, row_d;
  logic              capture, row_done;

  logic              busy_q, busy_d, bias_en_q, bias_en_d, ramp_en_q, ramp_en_d;
  logic              mem_reset_q, mem_reset_d, pixel_erase_q, pixel_erase_d;
  logic              pixel_expose_q, pixel_expose_d, cnt_drive_en_q, cnt_drive_en_d;
  logic [1:0]        mem_read_q, mem_read_d;
  logic [DATA_W-1:0] cnt_value_q, cnt_value_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    row_d   = row_q;
    capture = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = ERASE;
        cnt_d   = '0;
        exp_d   = expose_time;
      end
      ERASE: if (cnt_q == ERASE_LAST) begin
        state_d = EXPOSE;
        cnt_d   = '0;
      end else cnt_d = cnt_q + 1'b1;
      // The ">=" form makes expose_time=0 behave as a single cycle.
      EXPOSE: if ((cnt_q + 1'b1) >= CNT_W'(exp_q)) begin
        state_d = CONVERT;
        cnt_d   = '0;
      end else cnt_d = cnt_q + 1'b1;
      CONVERT: if (cnt_q == CONV_LAST) begin
        state_d = READ;
        cnt_d   = '0;
        row_d   = 1'b0;
      end else cnt_d = cnt_q + 1'b1;
      // READ count 0 is a dead cycle so the array never sees mem_read while
      // the counter code is still on the bus.
      READ: if (cnt_q == SETTLE_LAST) begin
        state_d = EMIT;
        cnt_d   = '0;
        capture = 1'b1;
      end else cnt_d = cnt_q + 1'b1;
      EMIT: if (row_done) begin
        if (row_q == 1'(NUM_ROWS - 1)) state_d = IDLE;
        else begin
          state_d = READ;
          cnt_d   = '0;
          row_d   = row_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so each one lines up with its state.
    busy_d         = (state_d != IDLE);
    bias_en_d      = state_d inside {ERASE, EXPOSE, CONVERT};
    pixel_erase_d  = (state_d == ERASE);
    mem_reset_d    = (state_d == ERASE);
    pixel_expose_d = (state_d == EXPOSE);
    ramp_en_d      = (state_d == CONVERT);
    cnt_drive_en_d = (state_d == CONVERT);
    cnt_value_d    = (state_d == CONVERT) ? cnt_d[DATA_W-1:0] : '0;
    mem_read_d     = (state_d == READ && cnt_d != '0) ? row_to_mem_read(row_d) : 2'b00;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      exp_q          <= '0;
      row_q          <= 1'b0;
      busy_q         <= 1'b0;
      bias_en_q      <= 1'b0;
      ramp_en_q      <= 1'b0;
      mem_reset_q    <= 1'b0;
      pixel_erase_q  <= 1'b0;
      pixel_expose_q <= 1'b0;
      mem_read_q     <= 2'b00;
      cnt_drive_en_q <= 1'b0;
      cnt_value_q    <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      exp_q          <= exp_d;
      row_q          <= row_d;
      busy_q         <= busy_d;
      bias_en_q      <= bias_en_d;
      ramp_en_q      <= ramp_en_d;
      mem_reset_q    <= mem_reset_d;
      pixel_erase_q  <= pixel_erase_d;
      pixel_expose_q <= pixel_expose_d;
      mem_read_q     <= mem_read_d;
      cnt_drive_en_q <= cnt_drive_en_d;
      cnt_value_q    <= cnt_value_d;
    end
  end

  assign busy         = busy_q;
  assign bias_en      = bias_en_q;
  assign ramp_en      = ramp_en_q;
  assign mem_reset    = mem_reset_q;
  assign pixel_erase  = pixel_erase_q;
  assign pixel_expose = pixel_expose_q;
  assign mem_read     = mem_read_q;
  assign cnt_drive_en = cnt_drive_en_q;
  assign cnt_value    = cnt_value_q;

  pixel_read_buffer #(.DATA_W(DATA_W)) u_read_buffer (
    .clk       (clk),
    .reset     (reset),
    .capture   (capture),
    .last_row  (row_q),
    .col1_in   (pix_data1_in),
    .col2_in   (pix_data2_in),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .row_done  (row_done)
  );

endmodule
